core_axi_rd_arbiter: RTL and testbench

// - Shares one AXI4-Lite read port to memory between instruction fetch (S0) and data load (S1).
// - Sits between core_ifetch / load unit and the memory interconnect.
// - Serialises requests: one outstanding transaction; grant held from AR capture to R handshake.

---
 rtl/core_axi_pkg.sv | 14 +
 rtl/core_axi_rd_arbiter_if.sv | 24 ++
 rtl/core_axi_rd_arbiter_rr_arbiter2.sv | 20 ++
 rtl/core_axi_rd_arbiter.sv | 108 ++++++++++
 tb/tb_core_axi_rd_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_axi_pkg.sv
// Shared AXI4-Lite read-arbiter definitions: response codes and FSM state encoding.
package core_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/core_axi_rd_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle shared by the requester ports and the memory port.
interface core_axi_rd_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  // Handshakes: a beat transfers on the rising clock edge where VALID and READY are both high.
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/core_axi_rd_arbiter_rr_arbiter2.sv
// Two-way combinational arbiter: round-robin against the last owner, or fixed S1 priority.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_mode,
  output logic [1:0] gnt
);

  // last = 1 means S1 owned the previous transaction.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_mode || !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_axi_rd_arbiter.sv
// Shares one AXI4-Lite read port between ifetch (S0) and load (S1); one transaction in flight.
module core_axi_rd_arbiter
  import core_axi_pkg::*;
#(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32,
  parameter int PRIO_MODE  = 0
) (
  input  logic                   CLK,
  input  logic                   NRST,
  core_axi_rd_arbiter_if.slave   S0,
  core_axi_rd_arbiter_if.slave   S1,
  core_axi_rd_arbiter_if.master  M,
  output logic [1:0]             GRANT,
  output logic                   BUSY,
  output fsm_state_e             STATE
);

  fsm_state_e            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            arb_gnt;
  logic                  last_q, last_d;
  logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  in_addr, in_data;
  logic                  rready_sel, r_fire;

  rr_arbiter2 u_arb (
    .req       ({S1.ARVALID, S0.ARVALID}),
    .last      (last_q),
    .prio_mode (PRIO_MODE != 0),
    .gnt       (arb_gnt)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d   = ST_ADDR;
          grant_d   = arb_gnt;
          araddr_d  = arb_gnt[1] ? S1.ARADDR : S0.ARADDR;
          arvalid_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (M.ARREADY) begin
          state_d   = ST_DATA;
          arvalid_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (r_fire) begin
          state_d = ST_IDLE;
          last_d  = grant_q[1];
          grant_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_addr    = (state_q == ST_ADDR);
  assign in_data    = (state_q == ST_DATA);
  assign rready_sel = (grant_q[0] & S0.RREADY) | (grant_q[1] & S1.RREADY);
  assign r_fire     = M.RVALID & M.RREADY;

  assign M.ARADDR  = araddr_q;
  assign M.ARVALID = arvalid_q;
  assign M.RREADY  = in_data & rready_sel;

  // The requester sees the memory's accept directly so AR completes end to end in one cycle.
  assign S0.ARREADY = in_addr & grant_q[0] & M.ARREADY;
  assign S1.ARREADY = in_addr & grant_q[1] & M.ARREADY;

  // R path: only the owner sees memory data; the other port reads all zeros.
  assign S0.RVALID = in_data & grant_q[0] & M.RVALID;
  assign S1.RVALID = in_data & grant_q[1] & M.RVALID;
  assign S0.RDATA  = (in_data & grant_q[0]) ? M.RDATA : '0;
  assign S1.RDATA  = (in_data & grant_q[1]) ? M.RDATA : '0;
  assign S0.RRESP  = (in_data & grant_q[0]) ? M.RRESP : 2'b00;
  assign S1.RRESP  = (in_data & grant_q[1]) ? M.RRESP : 2'b00;

  assign GRANT = grant_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign STATE = state_q;

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Bench for core_axi_rd_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_core_axi_rd_arbiter;
  import core_axi_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic NRST = 1'b1;
  logic sel  = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- common stimulus ----------------
  logic [AW-1:0] araddr_b [2];
  logic [1:0]    arvalid_b = 2'b00;
  logic [1:0]    rready_b  = 2'b00;
  logic          m_arready_b = 1'b0;
  logic          m_rvalid_b  = 1'b0;
  logic [DW-1:0] m_rdata_b   = '0;
  logic [1:0]    m_rresp_b   = 2'b00;

  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) s0_a ();
  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) s1_a ();
  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) m_a ();
  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) s0_b ();
  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) s1_b ();
  core_axi_rd_arbiter_if #(.AW(AW), .DW(DW)) m_b ();

  assign s0_a.ARADDR = araddr_b[0]; assign s0_a.ARVALID = arvalid_b[0]; assign s0_a.RREADY = rready_b[0];
  assign s1_a.ARADDR = araddr_b[1]; assign s1_a.ARVALID = arvalid_b[1]; assign s1_a.RREADY = rready_b[1];
  assign s0_b.ARADDR = araddr_b[0]; assign s0_b.ARVALID = arvalid_b[0]; assign s0_b.RREADY = rready_b[0];
  assign s1_b.ARADDR = araddr_b[1]; assign s1_b.ARVALID = arvalid_b[1]; assign s1_b.RREADY = rready_b[1];
  assign m_a.ARREADY = m_arready_b; assign m_a.RVALID = m_rvalid_b;
  assign m_a.RDATA   = m_rdata_b;   assign m_a.RRESP  = m_rresp_b;
  assign m_b.ARREADY = m_arready_b; assign m_b.RVALID = m_rvalid_b;
  assign m_b.RDATA   = m_rdata_b;   assign m_b.RRESP  = m_rresp_b;

  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b;
  fsm_state_e state_a, state_b;

  core_axi_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .PRIO_MODE(0)) dut_rr (
    .CLK(CLK), .NRST(NRST), .S0(s0_a), .S1(s1_a), .M(m_a),
    .GRANT(grant_a), .BUSY(busy_a), .STATE(state_a)
  );

  core_axi_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .PRIO_MODE(1)) dut_fp (
    .CLK(CLK), .NRST(NRST), .S0(s0_b), .S1(s1_b), .M(m_b),
    .GRANT(grant_b), .BUSY(busy_b), .STATE(state_b)
  );

  // Observed outputs of whichever instance is under test.
  logic [1:0]    grant_o, s_arready_o, s_rvalid_o;
  logic          busy_o, m_arvalid_o, m_rready_o;
  logic [AW-1:0] m_araddr_o;
  fsm_state_e    state_o;
  logic [DW-1:0] s_rdata_o [2];
  logic [1:0]    s_rresp_o [2];

  always_comb begin
    grant_o      = sel ? grant_b : grant_a;
    busy_o       = sel ? busy_b : busy_a;
    state_o      = sel ? state_b : state_a;
    m_arvalid_o  = sel ? m_b.ARVALID : m_a.ARVALID;
    m_araddr_o   = sel ? m_b.ARADDR : m_a.ARADDR;
    m_rready_o   = sel ? m_b.RREADY : m_a.RREADY;
    s_arready_o  = sel ? {s1_b.ARREADY, s0_b.ARREADY} : {s1_a.ARREADY, s0_a.ARREADY};
    s_rvalid_o   = sel ? {s1_b.RVALID, s0_b.RVALID} : {s1_a.RVALID, s0_a.RVALID};
    s_rdata_o[0] = sel ? s0_b.RDATA : s0_a.RDATA;
    s_rdata_o[1] = sel ? s1_b.RDATA : s1_a.RDATA;
    s_rresp_o[0] = sel ? s0_b.RRESP : s0_a.RRESP;
    s_rresp_o[1] = sel ? s1_b.RRESP : s1_a.RRESP;
  end

  // ---------------- memory model and scoreboard ----------------
  logic [DW-1:0]   mem      [16];
  logic [1:0]      resp_tab [16];
  logic [AW-1:0]   addr_reg [2];
  logic [DW+1:0]   exp_q0[$];
  logic [DW+1:0]   exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic raise(input int p, input logic [AW-1:0] a);
    arvalid_b[p] = 1'b1;
    araddr_b[p]  = a;
    addr_reg[p]  = a;
    if (p == 0) exp_q0.push_back({resp_tab[a], mem[a]});
    else        exp_q1.push_back({resp_tab[a], mem[a]});
  endtask

  task automatic apply_reset();
    NRST = 1'b0;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_m_arvalid", m_arvalid_o, 0);
    chk("rst_m_araddr", m_araddr_o, 0);
    chk("rst_m_rready", m_rready_o, 0);
    chk("rst_s_arready", s_arready_o, 0);
    chk("rst_s_rvalid", s_rvalid_o, 0);
    arvalid_b = 2'b00; rready_b = 2'b00;
    m_arready_b = 1'b0; m_rvalid_b = 1'b0; m_rdata_b = '0; m_rresp_b = 2'b00;
    exp_q0.delete(); exp_q1.delete();
    @(negedge CLK);
    NRST = 1'b1;
  endtask

  // Runs one transaction for port p; entered in IDLE just before the capturing edge.
  task automatic serve(input int p, input int ar_dly, input int r_stall);
    int q;
    logic [AW-1:0] a;
    logic [DW+1:0] e;
    q = 1 - p;
    @(negedge CLK); #1;
    chk("grant_owner", grant_o, 32'd1 << p);
    chk("m_arvalid_set", m_arvalid_o, 1);
    chk("m_araddr", m_araddr_o, addr_reg[p]);
    chk("busy_addr", busy_o, 1);
    chk("state_addr", state_o, ST_ADDR);
    for (int k = 0; k < ar_dly; k++) begin
      chk("arready_wait", s_arready_o[p], 0);
      @(negedge CLK); #1;
      chk("m_araddr_hold", m_araddr_o, addr_reg[p]);
      chk("m_arvalid_hold", m_arvalid_o, 1);
    end
    m_arready_b = 1'b1; #1;
    chk("arready_accept", s_arready_o[p], 1);
    chk("arready_other", s_arready_o[q], 0);
    a = m_araddr_o;
    @(negedge CLK);
    arvalid_b[p] = 1'b0; m_arready_b = 1'b0;
    m_rvalid_b = 1'b1; m_rdata_b = mem[a]; m_rresp_b = resp_tab[a];
    rready_b[p] = (r_stall == 0);
    #1;
    chk("m_arvalid_clear", m_arvalid_o, 0);
    chk("state_data", state_o, ST_DATA);
    chk("arready_after", s_arready_o[p], 0);
    for (int k = 0; k < r_stall; k++) begin
      chk("m_rready_stall", m_rready_o, 0);
      chk("rvalid_stall", s_rvalid_o[p], 1);
      chk("rdata_stall", s_rdata_o[p], mem[a]);
      @(negedge CLK); #1;
    end
    rready_b[p] = 1'b1; #1;
    chk("m_rready", m_rready_o, 1);
    chk("rvalid_owner", s_rvalid_o[p], 1);
    chk("rvalid_other", s_rvalid_o[q], 0);
    chk("rdata_other", s_rdata_o[q], 0);
    chk("rresp_other", s_rresp_o[q], 0);
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk("sb_rdata", s_rdata_o[p], e[DW-1:0]);
      chk("sb_rresp", s_rresp_o[p], e[DW+1:DW]);
    end
    @(negedge CLK);
    m_rvalid_b = 1'b0; rready_b[p] = 1'b0;
    #1;
    chk("grant_release", grant_o, 0);
    chk("busy_release", busy_o, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    int            exp_port;
    int            ar_dly;
    int            r_stall;
    logic          psel;
  } vec_t;

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]      = $urandom;
      resp_tab[i] = RESP_OKAY;
    end
    mem[4]       = 32'h0000_0013;
    resp_tab[6]  = RESP_SLVERR;
    resp_tab[10] = RESP_DECERR;

    vecs[0]  = '{1'b1, 2'b01, 4'h4, 4'h0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 4'h8, 4'hC, 0, 0, 0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 4'h0, 4'h0, 1, 3, 0, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 4'h2, 4'h6, 0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 4'hA, 4'h0, 1, 0, 2, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 4'h0, 4'h0, 0, 3, 0, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 4'h0, 4'hE, 1, $urandom_range(0, 2), 1, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 4'h3, 4'h5, 1, 0, 0, 1'b1};
    vecs[8]  = '{1'b0, 2'b10, 4'h0, 4'h7, 1, 0, 0, 1'b1};
    vecs[9]  = '{1'b0, 2'b10, 4'h0, 4'h9, 1, 2, 1, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1'b1};
    vecs[11] = '{1'b0, 2'b01, 4'hB, 4'h0, 0, 0, $urandom_range(0, 2), 1'b1};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) begin
        sel = vecs[i].psel;
        apply_reset();
      end
      if (vecs[i].req[0]) raise(0, vecs[i].a0);
      if (vecs[i].req[1]) raise(1, vecs[i].a1);
      #1;
      chk("ar_latency", m_arvalid_o, 0);
      serve(vecs[i].exp_port, vecs[i].ar_dly, vecs[i].r_stall);
    end

    // Reset while data is pending: everything drops at once, then a fresh request runs.
    sel = 1'b0;
    apply_reset();
    raise(0, 4'h5);
    @(negedge CLK); #1;
    chk("mid_state_addr", state_o, ST_ADDR);
    m_arready_b = 1'b1;
    @(negedge CLK);
    arvalid_b[0] = 1'b0; m_arready_b = 1'b0;
    m_rvalid_b = 1'b1; m_rdata_b = mem[5]; m_rresp_b = resp_tab[5]; rready_b[0] = 1'b0;
    #1;
    chk("mid_state_data", state_o, ST_DATA);
    chk("mid_rvalid", s_rvalid_o[0], 1);
    #2;
    apply_reset();
    raise(0, 4'h9);
    #1;
    chk("post_rst_latency", m_arvalid_o, 0);
    serve(0, 1, 0);

    // Memory data outside a transaction is not accepted or forwarded.
    @(negedge CLK);
    m_rvalid_b = 1'b1; m_rdata_b = 32'hDEAD_BEEF; rready_b = 2'b11;
    #1;
    chk("idle_m_rready", m_rready_o, 0);
    chk("idle_s_rvalid", s_rvalid_o, 0);
    chk("idle_s0_rdata", s_rdata_o[0], 0);
    @(negedge CLK);
    m_rvalid_b = 1'b0; rready_b = 2'b00;
    #1;
    chk("idle_busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
